fft_bitrev_buf: RTL and testbench
=================================

# fft_bitrev_buf

Output reorder buffer placed directly after the final radix-2 pipeline FFT stage. It consumes that stage's bit-reversed-order stream (enable, index, complex sample) and re-emits each 2^N-point frame in natural frequency order. Two ping-pong RAM banks let one frame be written while the previous one is read, so back-to-back frames produce back-to-back output frames.

## Interface
- width, 16: bits per real/imag component (signed two's complement)
- N, 6: log2 of FFT length; frame = 2^N samples
- clk  in  1  rising-edge clock
- areset  in  1  reset; one clock, synchronous and active-high
- en_in  in  1  input sample valid (upstream en_out)
- cnt_in  in  N  upstream sample index within frame, 0..2^N-1, bit-reversed frequency order
- xin_re  in  width  input real part
- xin_im  in  width  input imag part
- en_out  out  1  output sample valid
- cnt_out  out  N  natural frequency index k of yout
- yout_re  out  width  output real part, X[k]
- yout_im  out  width  output imag part, X[k]
- err  out  1  sticky index-sequence error

## Operation
- Storage: 2 banks × 2^N words, each word {re,im} = 2·width bits; address = {bank, N-bit offset}.
- Write side: when en_in=1, write xin to address {wr_bank, bitrev(cnt_in)}. bitrev reverses all N bits.
- Frame end: a write with cnt_in = 2^N-1 sets full[wr_bank] and toggles wr_bank.
- Expected-index tracker exp_cnt (N bits, wraps): if en_in=1 and cnt_in ≠ exp_cnt, set err (sticky until reset); the sample is still written; exp_cnt <= cnt_in+1 on every en_in.
- Gaps (en_in=0 mid-frame) are allowed; nothing is written.
- Read FSM, states IDLE, READ:
  - IDLE: if full[rd_bank]=1 -> READ, rd_cnt=0.
  - READ: each cycle read address {rd_bank, rd_cnt}, rd_cnt++. At rd_cnt = 2^N-1: clear full[rd_bank], toggle rd_bank; if full[other bank] is already 1 (or being set this cycle), stay in READ with rd_cnt=0, otherwise go to IDLE.
- Set and clear of full[] in the same cycle always target different banks; both take effect.
- Overflow cannot occur: a frame takes ≥ 2^N write cycles and a read takes exactly 2^N, so a bank is always drained before it is rewritten. No back-pressure port.

## Timing
- Reset (areset=1 at a clock edge): en_out=0, cnt_out=0, yout_re=yout_im=0, err=0, wr_bank=rd_bank=0, full=2'b00, exp_cnt=0, FSM=IDLE. RAM contents are not cleared (don't care). A partially written or partially read frame is discarded.
- RAM read port is registered, with 1 cycle latency. The output register adds 1 more cycle.
- If the last write of a frame (cnt_in=2^N-1) occurs at edge T, then READ begins at T+1, and en_out=1 with cnt_out=0 at T+2. en_out stays high for exactly 2^N consecutive cycles with cnt_out = 0..2^N-1.
- Back-to-back input frames give a continuous output with no idle cycle between frames.
- en_out=0 implies cnt_out/yout hold their previous values.

## Structure
- Shared package fft_pkg: bitrev(N) function, default WIDTH/N constants; the upstream stages use the same.
- One sub-module, fft_dpram: simple dual-port RAM with one write port and one registered read port, depth 2^(N+1), data width 2·width.
- Top level holds the write logic, full flags, read FSM and output register (~150-250 lines).

## Test plan
- N=3, one frame with en_in continuous, cnt_in=0..7, xin_re=cnt_in, xin_im=-cnt_in -> 2 cycles after the last write, 8 outputs with cnt_out=0..7 and yout_re=0,4,2,6,1,5,3,7, yout_im the negatives; err=0.
- N=3, three frames back-to-back -> 24 consecutive en_out=1 cycles with no gap; each frame is reordered correctly.
- N=3, frame with en_in low every other cycle -> output identical to the first scenario; output starts 2 cycles after the cnt_in=7 write.
- cnt_in sequence 0,1,2,5,6,7 -> err rises the cycle after the cnt_in=5 sample and stays 1; the frame still closes at cnt_in=7 and is read out.
- areset pulsed after 3 output samples of frame A, while frame B is half written -> all outputs and err return to 0 next cycle; no further en_out until a complete new frame is written.
- Default N=6, random data -> output matches a bit-reversal reference model for 10 consecutive frames.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT package: default sizing, read-side state encoding and the
// bit-reversal helper used by every radix-2 stage.
package fft_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 6;
  localparam int MAX_N     = 16;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_t;

  // Reverses the low n bits of x; bits above n come back as zero.
  function automatic logic [MAX_N-1:0] bitrev(input logic [MAX_N-1:0] x, input int n);
    logic [MAX_N-1:0] r;
    logic [MAX_N-1:0] v;
    r = '0;
    v = x;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r = {r[MAX_N-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output (one cycle read latency).
module fft_dpram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array and its read register have no reset so the tools can map
  // them onto a block RAM; the control logic never reads an unwritten word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_buf.sv
// Output reorder buffer after the last radix-2 stage: writes the bit-reversed
// stream into ping-pong banks and re-emits each frame in natural order.
module fft_bitrev_buf
  import fft_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    en_in,
  input  logic [N-1:0]            cnt_in,
  input  logic signed [width-1:0] xin_re,
  input  logic signed [width-1:0] xin_im,
  output logic                    en_out,
  output logic [N-1:0]            cnt_out,
  output logic signed [width-1:0] yout_re,
  output logic signed [width-1:0] yout_im,
  output logic                    err
);

  localparam int AW = N + 1;
  localparam int DW = 2 * width;

  rd_state_t      state, state_nxt;
  logic           wr_bank, rd_bank;
  logic [1:0]     full, full_nxt;
  logic [N-1:0]   exp_cnt, rd_cnt, rd_idx, wr_off;
  logic           frame_done, other_ready, rd_en, rd_last, rd_vld;
  logic [DW-1:0]  rd_data;

  assign frame_done = en_in && (cnt_in == '1);
  assign wr_off     = N'(bitrev(MAX_N'(cnt_in), N));

  fft_dpram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (en_in),
    .waddr ({wr_bank, wr_off}),
    .wdata ({xin_re, xin_im}),
    .re    (rd_en),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (rd_data)
  );

  // Write side: bank select and index-sequence supervision.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (areset) begin
      wr_bank <= 1'b0;
      exp_cnt <= '0;
      err     <= 1'b0;
    end else if (en_in) begin
      exp_cnt <= cnt_in + 1'b1;
      if (cnt_in != exp_cnt) err <= 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  // IDLE issues offset 0 itself, so the first sample is fetched the cycle
  // after the frame closes and READ covers offsets 1..2^N-1.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    rd_last     = 1'b0;
    other_ready = full[~rd_bank] || (frame_done && (wr_bank != rd_bank));
    case (state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          rd_en     = 1'b1;
          state_nxt = RD_READ;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if (rd_cnt == '1) begin
          rd_last   = 1'b1;
          state_nxt = other_ready ? RD_READ : RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Set and clear always hit different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (frame_done) full_nxt[wr_bank] = 1'b1;
    if (rd_last)    full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (areset) state <= RD_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
    end else begin
      full   <= full_nxt;
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        rd_idx <= rd_cnt;
      end
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  // Output register: holds the last sample while en_out is low.
  always_ff @(posedge clk) begin
    if (areset) begin
      en_out  <= 1'b0;
      cnt_out <= '0;
      yout_re <= '0;
      yout_im <= '0;
    end else begin
      en_out <= rd_vld;
      if (rd_vld) begin
        cnt_out <= rd_idx;
        yout_re <= rd_data[DW-1:width];
        yout_im <= rd_data[width-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Bench for fft_bitrev_buf: an N=3 and an N=6 instance, a frame-level
// reference model checked every cycle, and hand-computed pins on top.
module tb_fft_bitrev_buf;

  typedef struct {
    int cyc;
    int k;
    int re;
    int im;
  } exp_t;

  logic clk = 1'b0;
  logic areset;

  logic               en3, eo3, err3;
  logic [2:0]         cnt3, co3;
  logic signed [15:0] xre3, xim3, yre3, yim3;
  logic               en6, eo6, err6;
  logic [5:0]         cnt6, co6;
  logic signed [15:0] xre6, xim6, yre6, yim6;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  fft_bitrev_buf #(.width(16), .N(3)) dut3 (
    .clk(clk), .areset(areset), .en_in(en3), .cnt_in(cnt3), .xin_re(xre3), .xin_im(xim3),
    .en_out(eo3), .cnt_out(co3), .yout_re(yre3), .yout_im(yim3), .err(err3)
  );

  fft_bitrev_buf #(.width(16), .N(6)) dut6 (
    .clk(clk), .areset(areset), .en_in(en6), .cnt_in(cnt6), .xin_re(xre6), .xin_im(xim6),
    .en_out(eo6), .cnt_out(co6), .yout_re(yre6), .yout_im(yim6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int   mem_re [2][2][64];
  int   mem_im [2][2][64];
  int   wrb [2], expc [2], errx [2], nfree [2];
  int   hcnt [2], hre [2], him [2];
  exp_t q0 [$];
  exp_t q1 [$];

  function automatic int brev(input int x, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) r += ((x >> i) & 1) << (n - 1 - i);
    return r;
  endfunction

  // One input edge: a sample lands at natural index brev(cnt) of the current
  // bank; a closing sample schedules the whole frame, back to back with any
  // frame still being emitted, first sample two edges after the close.
  task automatic model_edge(input int id, input int n, input bit rst, input bit en,
                            input int cnt, input int re, input int im);
    int   sz, b, start;
    exp_t e;
    sz = 1 << n;
    if (rst) begin
      wrb[id] = 0; expc[id] = 0; errx[id] = 0; nfree[id] = 0;
      hcnt[id] = 0; hre[id] = 0; him[id] = 0;
      if (id == 0) q0.delete(); else q1.delete();
    end else if (en) begin
      if (cnt != expc[id]) errx[id] = 1;
      expc[id] = (cnt + 1) % sz;
      b = wrb[id];
      mem_re[id][b][brev(cnt, n)] = re;
      mem_im[id][b][brev(cnt, n)] = im;
      if (cnt == sz - 1) begin
        start = (cyc + 2 > nfree[id]) ? cyc + 2 : nfree[id];
        for (int k = 0; k < sz; k++) begin
          e.cyc = start + k; e.k = k; e.re = mem_re[id][b][k]; e.im = mem_im[id][b][k];
          if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        nfree[id] = start + sz;
        wrb[id] = 1 - b;
      end
    end
  endtask

  task automatic cmp(input int id, input int eo, input int co, input int re, input int im,
                     input int er);
    exp_t  e;
    bit    hit = 1'b0;
    string p = (id == 0) ? "n3" : "n6";
    if (id == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin e = q0.pop_front(); hit = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin e = q1.pop_front(); hit = 1'b1; end
    end
    if (hit) begin hcnt[id] = e.k; hre[id] = e.re; him[id] = e.im; end
    check({p, " en_out"}, eo, int'(hit));
    check({p, " cnt_out"}, co, hcnt[id]);
    check({p, " yout_re"}, re, hre[id]);
    check({p, " yout_im"}, im, him[id]);
    check({p, " err"}, er, errx[id]);
  endtask

  always @(posedge clk) begin
    model_edge(0, 3, areset, en3, int'(cnt3), int'(xre3), int'(xim3));
    model_edge(1, 6, areset, en6, int'(cnt6), int'(xre6), int'(xim6));
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, int'(eo3), int'(co3), int'(yre3), int'(yim3), int'(err3));
      cmp(1, int'(eo6), int'(co6), int'(yre6), int'(yim6), int'(err6));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put3(input bit en, input int cnt, input int re, input int im);
    en3 = en; cnt3 = 3'(cnt); xre3 = 16'(re); xim3 = 16'(im);
    tick();
  endtask

  task automatic put6(input bit en, input int cnt, input int re, input int im);
    en6 = en; cnt6 = 6'(cnt); xre6 = 16'(re); xim6 = 16'(im);
    tick();
  endtask

  // Hand-computed pin for the ramp frame re=cnt, im=-cnt on the N=3 instance.
  task automatic expect_ramp3(input int t_last, input string tag);
    int re_ref [8];
    bit seen = 1'b0;
    re_ref = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (eo3) seen = 1'b1;
    end
    check({tag, " output seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, " latency"}, (cyc - 1) - t_last, 2);
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        check({tag, " pin en_out"}, int'(eo3), 1);
        check({tag, " pin cnt_out"}, int'(co3), k);
        check({tag, " pin yout_re"}, int'(yre3), re_ref[k]);
        check({tag, " pin yout_im"}, int'(yim3), -re_ref[k]);
      end
    end
  endtask

  task automatic measure_run(input int id, input int max_wait, output int run);
    int w = 0;
    run = 0;
    while (((id == 0) ? eo3 : eo6) == 1'b0 && w < max_wait) begin @(negedge clk); w++; end
    while (((id == 0) ? eo3 : eo6) == 1'b1 && run < 1000) begin run++; @(negedge clk); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, run, highs;
    int seq4 [6];
    int seqb [4];
    seq4 = '{0, 1, 2, 5, 6, 7};
    seqb = '{0, 1, 3, 4};
    areset = 1'b1;
    en3 = 1'b0; cnt3 = '0; xre3 = '0; xim3 = '0;
    en6 = 1'b0; cnt6 = '0; xre6 = '0; xim6 = '0;
    tick(); tick();
    areset = 1'b0;
    chk_on = 1'b1;
    check("reset en_out", int'(eo3), 0);
    check("reset err", int'(err3), 0);

    // Single continuous ramp frame.
    for (int c = 0; c < 8; c++) put3(1'b1, c, c, -c);
    en3 = 1'b0;
    t = cyc - 1;
    expect_ramp3(t, "ramp");
    repeat (20) tick();

    // Three frames back to back must come out as one unbroken run.
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int c = 0; c < 8; c++) put3(1'b1, c, 100 * f + c + 10, -(50 * f + 3 * c));
        en3 = 1'b0;
      end
      begin
        measure_run(0, 60, run);
        check("b2b run length", run, 24);
      end
    join
    repeat (20) tick();

    // Same ramp with a gap after every sample.
    for (int c = 0; c < 8; c++) begin
      put3(1'b1, c, c, -c);
      if (c == 7) t = cyc - 1;
      put3(1'b0, 0, 0, 0);
    end
    expect_ramp3(t, "gapped");
    repeat (20) tick();

    // Skipped indices 3,4: err rises after the cnt=5 sample; frame still closes.
    for (int i = 0; i < 6; i++) begin
      put3(1'b1, seq4[i], 50 + seq4[i], seq4[i] - 50);
      @(negedge clk);
      check("seq err", int'(err3), (i >= 3) ? 1 : 0);
    end
    en3 = 1'b0;
    measure_run(0, 20, run);
    check("seq frame run", run, 8);
    repeat (10) tick();
    check("seq err sticky", int'(err3), 1);

    // Reset mid-read of frame A while frame B is half written.
    areset = 1'b1; tick(); areset = 1'b0;
    for (int c = 0; c < 8; c++) put3(1'b1, c, c + 20, 7 - c);
    for (int i = 0; i < 4; i++) put3(1'b1, seqb[i], 200 + i, -200 - i);
    check("pre-reset en_out", int'(eo3), 1);
    check("pre-reset err", int'(err3), 1);
    areset = 1'b1; en3 = 1'b0;
    tick();
    areset = 1'b0;
    check("post-reset en_out", int'(eo3), 0);
    check("post-reset cnt_out", int'(co3), 0);
    check("post-reset yout_re", int'(yre3), 0);
    check("post-reset yout_im", int'(yim3), 0);
    check("post-reset err", int'(err3), 0);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eo3) highs++;
    end
    check("post-reset silent", highs, 0);
    tick();
    for (int c = 0; c < 8; c++) put3(1'b1, c, c, -c);
    en3 = 1'b0;
    t = cyc - 1;
    expect_ramp3(t, "after reset");
    repeat (20) tick();

    // Default size: ten random frames back to back.
    fork
      begin
        for (int f = 0; f < 10; f++)
          for (int c = 0; c < 64; c++)
            put6(1'b1, c, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
        en6 = 1'b0;
      end
      begin
        measure_run(1, 200, run);
        check("n6 ten-frame run", run, 640);
      end
    join
    repeat (20) tick();
    check("n6 err", int'(err6), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
